sobel_pipe: RTL and testbench

//   Pipelined, parametrised 3x3 Sobel edge operator with valid/ready flow control.

---
 rtl/sobel_pkg.sv | 17 +
 rtl/sobel_pipe_if.sv | 25 ++
 rtl/sobel_grad3x3.sv | 24 ++
 rtl/sobel_pipe.sv | 116 +++++++++++
 tb/tb_sobel_pipe.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared magnitude-mode codes and width helpers for the Sobel datapath
package sobel_pkg;
    localparam logic [1:0] SOBEL_MODE_L1  = 2'd0;
    localparam logic [1:0] SOBEL_MODE_GX  = 2'd1;
    localparam logic [1:0] SOBEL_MODE_GY  = 2'd2;
    localparam logic [1:0] SOBEL_MODE_MAX = 2'd3;

    // width of the pre-shift magnitude: |gx|+|gy| needs one bit above a partial sum
    function automatic int mag_w(input int pix_w);
        return pix_w + 3;
    endfunction

    // width wide enough to compare the shifted magnitude against the output ceiling
    function automatic int sat_cmp_w(input int pix_w, input int out_w);
        return (mag_w(pix_w) > out_w) ? mag_w(pix_w) : out_w;
    endfunction
endpackage

// File: rtl/sobel_pipe_if.sv
// sobel_pipe_if: window-in / magnitude-out valid-ready bundle for the Sobel operator
interface sobel_pipe_if #(
    parameter int PIX_W = 8,
    parameter int OUT_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [9*PIX_W-1:0] in_win;
    logic [1:0]         mode;
    logic [OUT_W-1:0]   thresh;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_mag;
    logic               out_edge;

    modport master (
        output in_valid, in_win, mode, thresh, out_ready,
        input  in_ready, out_valid, out_mag, out_edge
    );

    modport slave (
        input  in_valid, in_win, mode, thresh, out_ready,
        output in_ready, out_valid, out_mag, out_edge
    );
endinterface

// File: rtl/sobel_grad3x3.sv
// sobel_grad3x3: combinational positive/negative Sobel partial sums of a flat 3x3 window
module sobel_grad3x3 #(
    parameter int PIX_W = 8
) (
    input  logic [9*PIX_W-1:0] i_win,
    output logic [PIX_W+1:0]   o_gxp,
    output logic [PIX_W+1:0]   o_gxn,
    output logic [PIX_W+1:0]   o_gyp,
    output logic [PIX_W+1:0]   o_gyn
);
    localparam int SW = PIX_W + 2;

    logic [SW-1:0] w_p [9];

    for (genvar k = 0; k < 9; k++) begin : g_pix
        assign w_p[k] = SW'(i_win[k*PIX_W +: PIX_W]);
    end

    // each sum is at most 4*(2^PIX_W-1), so PIX_W+2 bits never wrap
    assign o_gxp = w_p[2] + (w_p[5] << 1) + w_p[8];
    assign o_gxn = w_p[0] + (w_p[3] << 1) + w_p[6];
    assign o_gyp = w_p[6] + (w_p[7] << 1) + w_p[8];
    assign o_gyn = w_p[0] + (w_p[1] << 1) + w_p[2];
endmodule

// File: rtl/sobel_pipe.sv
// sobel_pipe: three-stage Sobel magnitude/edge pipeline with global-stall valid/ready flow
module sobel_pipe
    import sobel_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int OUT_W = 8,
    parameter int SHIFT = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    sobel_pipe_if.slave  bus
);
    localparam int SW = PIX_W + 2;
    localparam int MW = mag_w(PIX_W);
    localparam int CW = sat_cmp_w(PIX_W, OUT_W);

    logic                    w_adv;
    logic [SW-1:0]           w_gxp, w_gxn, w_gyp, w_gyn;
    logic signed [PIX_W+2:0] w_gx, w_gy;
    logic [SW-1:0]           w_ax, w_ay;
    logic [MW-1:0]           w_m, w_s;
    logic [CW-1:0]           w_s_ext;
    logic [OUT_W-1:0]        w_mag;
    logic                    w_edge;

    logic                    r_v1, r_v2, r_v3;
    logic [SW-1:0]           r_gxp, r_gxn, r_gyp, r_gyn;
    logic [SW-1:0]           r_ax, r_ay;
    logic [1:0]              r_mode1, r_mode2;
    logic [OUT_W-1:0]        r_thr1, r_thr2;
    logic [OUT_W-1:0]        r_mag;
    logic                    r_edge;

    // the whole pipe moves together: it may advance whenever the output slot is free or being drained
    assign w_adv        = !r_v3 || bus.out_ready;
    assign bus.in_ready = w_adv;

    sobel_grad3x3 #(.PIX_W(PIX_W)) u_grad (
        .i_win (bus.in_win),
        .o_gxp (w_gxp),
        .o_gxn (w_gxn),
        .o_gyp (w_gyp),
        .o_gyn (w_gyn)
    );

    assign w_gx = $signed({1'b0, r_gxp}) - $signed({1'b0, r_gxn});
    assign w_gy = $signed({1'b0, r_gyp}) - $signed({1'b0, r_gyn});
    assign w_ax = w_gx[PIX_W+2] ? SW'(-w_gx) : SW'(w_gx);
    assign w_ay = w_gy[PIX_W+2] ? SW'(-w_gy) : SW'(w_gy);

    assign w_m = (r_mode2 == SOBEL_MODE_L1) ? MW'(r_ax) + MW'(r_ay) :
                 (r_mode2 == SOBEL_MODE_GX) ? MW'(r_ax) :
                 (r_mode2 == SOBEL_MODE_GY) ? MW'(r_ay) :
                 (r_ax > r_ay)              ? MW'(r_ax) : MW'(r_ay);

    // saturate in a width that holds both the shifted magnitude and the output ceiling
    assign w_s     = w_m >> SHIFT;
    assign w_s_ext = CW'(w_s);
    assign w_mag   = (w_s_ext > CW'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : w_s_ext[OUT_W-1:0];
    assign w_edge  = (w_mag >= r_thr2);

    // stage 1: partial sums plus the window's mode/threshold sideband
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_v1    <= 1'b0;
            r_gxp   <= '0;
            r_gxn   <= '0;
            r_gyp   <= '0;
            r_gyn   <= '0;
            r_mode1 <= '0;
            r_thr1  <= '0;
        end else if (w_adv) begin
            r_v1    <= bus.in_valid;
            r_gxp   <= w_gxp;
            r_gxn   <= w_gxn;
            r_gyp   <= w_gyp;
            r_gyn   <= w_gyn;
            r_mode1 <= bus.mode;
            r_thr1  <= bus.thresh;
        end
    end

    // stage 2: absolute gradients, sideband follows
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_v2    <= 1'b0;
            r_ax    <= '0;
            r_ay    <= '0;
            r_mode2 <= '0;
            r_thr2  <= '0;
        end else if (w_adv) begin
            r_v2    <= r_v1;
            r_ax    <= w_ax;
            r_ay    <= w_ay;
            r_mode2 <= r_mode1;
            r_thr2  <= r_thr1;
        end
    end

    // stage 3: selected, normalised, saturated magnitude and its edge flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_v3   <= 1'b0;
            r_mag  <= '0;
            r_edge <= 1'b0;
        end else if (w_adv) begin
            r_v3   <= r_v2;
            r_mag  <= w_mag;
            r_edge <= w_edge;
        end
    end

    assign bus.out_valid = r_v3;
    assign bus.out_mag   = r_mag;
    assign bus.out_edge  = r_edge;
endmodule

// File: tb/tb_sobel_pipe.sv
// tb_sobel_pipe: directed and randomized checks of sobel_pipe against an arithmetic Sobel model
module tb_sobel_pipe;
    typedef int win_t [9];

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   exp_q [$];
    int   n_acc = 0;
    int   n_out = 0;
    bit   got;
    int   o_mag;
    int   o_edge;
    bit   held;
    logic [7:0] h_mag;
    logic       h_edge;

    always #5 clock = ~clock;

    sobel_pipe_if #(.PIX_W(8), .OUT_W(8)) bus ();

    sobel_pipe #(.PIX_W(8), .OUT_W(8), .SHIFT(1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [71:0] mk(win_t p);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(p[k]);
        return w;
    endfunction

    function automatic logic [71:0] rnd_win();
        logic [71:0] w;
        bit ext;
        ext = ($urandom_range(0, 3) == 0);
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = ext ? 8'($urandom_range(0, 1) * 255) : 8'($urandom);
        return w;
    endfunction

    // returns 2*magnitude + edge, computed straight from the Sobel definition
    function automatic int model(logic [71:0] w, logic [1:0] md, logic [7:0] th);
        int p [9];
        int gx, gy, ax, ay, m, s, mag;
        for (int k = 0; k < 9; k++) p[k] = int'(w[k*8 +: 8]);
        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        case (md)
            2'd0:    m = ax + ay;
            2'd1:    m = ax;
            2'd2:    m = ay;
            default: m = (ax > ay) ? ax : ay;
        endcase
        s = m / 2;
        mag = (s > 255) ? 255 : s;
        return 2*mag + ((mag >= int'(th)) ? 1 : 0);
    endfunction

    task automatic chk(string tag, int obs, int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // one clock: check outputs at the falling edge, score handshakes, then pass the rising edge
    task automatic step();
        int e;
        @(negedge clock);
        got = 0;
        if (held) begin
            chk("hold_valid", int'(bus.out_valid), 1);
            chk("hold_mag", int'(bus.out_mag), int'(h_mag));
            chk("hold_edge", int'(bus.out_edge), int'(h_edge));
        end
        chk("in_ready", int'(bus.in_ready), int'(!(bus.out_valid && !bus.out_ready)));
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("spurious_out", int'(bus.out_valid), 0);
            else begin
                e = exp_q.pop_front();
                chk("out_mag", int'(bus.out_mag), e / 2);
                chk("out_edge", int'(bus.out_edge), e % 2);
                o_mag = int'(bus.out_mag);
                o_edge = int'(bus.out_edge);
                got = 1;
                n_out++;
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.in_win, bus.mode, bus.thresh));
            n_acc++;
        end
        held = bus.out_valid && !bus.out_ready;
        h_mag = bus.out_mag;
        h_edge = bus.out_edge;
        @(posedge clock);
        #1;
    endtask

    task automatic directed(string tag, win_t p, logic [1:0] md, logic [7:0] th, int emag, int eedge);
        int n;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_win = mk(p);
        bus.mode = md;
        bus.thresh = th;
        step();
        bus.in_valid = 1'b0;
        n = 1;
        while (!got && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, n - 1, 3);
        chk({tag, "_mag"}, o_mag, emag);
        chk({tag, "_edge"}, o_edge, eedge);
    endtask

    task automatic drain();
        int c;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        c = 0;
        while (exp_q.size() > 0 && c < 20) begin
            step();
            c++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        win_t w;
        int c, a0, o0;
        held = 0;
        bus.in_valid = 1'b0;
        bus.in_win = '0;
        bus.mode = 2'd0;
        bus.thresh = 8'd0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_mag", int'(bus.out_mag), 0);
        chk("rst_edge", int'(bus.out_edge), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        w = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
        directed("uniform", w, 2'd0, 8'd1, 0, 0);
        w = '{0, 0, 50, 0, 0, 50, 0, 0, 50};
        directed("col50_gx", w, 2'd1, 8'd100, 100, 1);
        w = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
        directed("step_l1", w, 2'd0, 8'd255, 255, 1);
        directed("step_gy", w, 2'd2, 8'd1, 0, 0);
        w = '{0, 0, 0, 0, 0, 0, 80, 80, 80};
        directed("row80_max", w, 2'd3, 8'd200, 160, 0);
        directed("row80_l1", w, 2'd0, 8'd160, 160, 1);

        a0 = n_acc;
        o0 = n_out;
        c = 0;
        while ((n_acc - a0 < 8 || exp_q.size() > 0) && c < 100) begin
            bus.in_valid = (n_acc - a0 < 8);
            bus.in_win = rnd_win();
            bus.mode = 2'($urandom);
            bus.thresh = 8'($urandom);
            bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
            step();
            c++;
        end
        chk("stream_in", n_acc - a0, 8);
        chk("stream_out", n_out - o0, 8);

        for (int i = 0; i < 300; i++) begin
            bus.in_valid = ($urandom_range(0, 9) < 7);
            bus.in_win = rnd_win();
            bus.mode = 2'($urandom);
            bus.thresh = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        drain();

        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_win = rnd_win();
            bus.mode = 2'($urandom);
            bus.thresh = 8'($urandom);
            step();
        end
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(bus.out_valid), 0);
        chk("async_rst_mag", int'(bus.out_mag), 0);
        exp_q.delete();
        held = 0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_rst_valid", int'(bus.out_valid), 0);
        end
        w = '{0, 0, 50, 0, 0, 50, 0, 0, 50};
        directed("after_rst", w, 2'd1, 8'd101, 100, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
